// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the data-memory arbiter slice.
package dmem_pkg;

  localparam int DATA_W          = 32;
  localparam int DEPTH           = 16;
  localparam int NUM_REQ_DEFAULT = 2;
  localparam int ID_W            = $clog2(NUM_REQ_DEFAULT);

  function automatic logic addr_in_range(input logic [DATA_W-1:0] a, input int depth);
    return (a < DATA_W'(depth));
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = dmem_pkg::NUM_REQ_DEFAULT,
  parameter int ID_W    = dmem_pkg::ID_W
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    gidx
);
  import dmem_pkg::*;

  logic            found;
  int              pos;
  logic [ID_W-1:0] idx;

  // Scan NUM_REQ positions starting at ptr; first hit wins.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    pos   = 0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end else begin
        pos = pos;
      end
      idx = ID_W'(pos);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin sharing of a single-port data memory among NUM_REQ cores,
// with range checking and one-cycle read-response routing.
module dmem_arbiter #(
  parameter int NUM_REQ = dmem_pkg::NUM_REQ_DEFAULT,
  parameter int DEPTH   = dmem_pkg::DEPTH,
  parameter int AW      = dmem_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    we,
  input  logic [NUM_REQ*AW-1:0] addr,
  input  logic [NUM_REQ*AW-1:0] wdata,
  output logic [NUM_REQ-1:0]    ack,
  output logic [NUM_REQ-1:0]    rvalid,
  output logic [AW-1:0]         rdata,
  output logic [NUM_REQ-1:0]    err,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [AW-1:0]         mem_addr,
  output logic [AW-1:0]         mem_wdata,
  input  logic [AW-1:0]         mem_rdata
);
  import dmem_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   gidx;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   next_ptr;
  logic [IDX_W-1:0]   resp_id;
  logic               resp_pending;
  logic               granted;
  logic               in_range;
  logic               mem_issue;
  logic               sel_we;
  logic [AW-1:0]      sel_addr;
  logic [AW-1:0]      sel_wdata;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (IDX_W)
  ) u_rr (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (grant),
    .gidx  (gidx)
  );

  // Grant decode and memory command drive; everything is forced quiet in reset.
  always_comb begin
    sel_addr  = addr[gidx*AW +: AW];
    sel_wdata = wdata[gidx*AW +: AW];
    sel_we    = we[gidx];
    granted   = (|grant) && !rst;
    in_range  = addr_in_range(sel_addr, DEPTH);
    mem_issue = granted && in_range;
    ack       = granted ? grant : '0;
    err       = (granted && !in_range) ? grant : '0;
    mem_we    = mem_issue && sel_we;
    mem_re    = mem_issue && !sel_we;
    mem_addr  = mem_issue ? sel_addr : '0;
    mem_wdata = mem_issue ? sel_wdata : '0;
    next_ptr  = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
  end

  // Route the memory's registered read data to whoever issued last cycle's read.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (resp_pending && !rst) begin
      rvalid[resp_id] = 1'b1;
      rdata           = mem_rdata;
    end else begin
      rvalid = '0;
      rdata  = '0;
    end
  end

  // Pointer and pending-response state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      resp_pending <= 1'b0;
      resp_id      <= '0;
    end else begin
      if (granted) begin
        rr_ptr <= next_ptr;
      end else begin
        rr_ptr <= rr_ptr;
      end
      resp_pending <= mem_issue && !sel_we;
      if (mem_issue && !sel_we) begin
        resp_id <= gidx;
      end else begin
        resp_id <= resp_id;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic
// checked against a behavioural model of the arbitration and memory.
module tb_dmem_arbiter;
  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  we = '0;
  logic [N*32-1:0] addr = '0;
  logic [N*32-1:0] wdata = '0;
  logic [N-1:0]  ack, rvalid, err;
  logic [31:0]   rdata, mem_addr, mem_wdata;
  logic          mem_we, mem_re;
  logic [31:0]   mem_rdata = 32'h0;
  logic [31:0]   mem [16];

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  logic [31:0] ref_mem [16];
  int          m_ptr = 0;
  bit          m_pend = 1'b0;
  int          m_pid = 0;
  logic [31:0] m_pdata = 32'h0;

  logic [N-1:0] obs_ack, obs_err, obs_rvalid;
  logic [31:0]  obs_rdata;
  logic         obs_re;
  logic [31:0]  init_data [16];

  dmem_arbiter #(.NUM_REQ(N), .DEPTH(16), .AW(32)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rvalid(rvalid), .rdata(rdata), .err(err),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port memory with a registered read port.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr[3:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
    req[i] = 1'b1;
    we[i]  = w;
    addr[32*i +: 32]  = a;
    wdata[32*i +: 32] = d;
  endtask

  // One clock: compare all outputs against the model mid-cycle, then advance the model.
  task automatic tick();
    int g, idx;
    bit ok;
    logic [31:0] a, d;
    logic [N-1:0] e_ack, e_err, e_rv;
    @(negedge clk);
    g = -1;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && req[idx]) g = idx;
      end
    end
    a = (g >= 0) ? addr[32*g +: 32] : 32'h0;
    d = (g >= 0) ? wdata[32*g +: 32] : 32'h0;
    ok = (g >= 0) && (a < 32'd16);
    e_ack = (g >= 0) ? N'(1 << g) : '0;
    e_err = (g >= 0 && !ok) ? e_ack : '0;
    e_rv  = (!rst && m_pend) ? N'(1 << m_pid) : '0;
    chk("ack", 32'(ack), 32'(e_ack));
    chk("err", 32'(err), 32'(e_err));
    chk("rvalid", 32'(rvalid), 32'(e_rv));
    chk("rdata", rdata, (!rst && m_pend) ? m_pdata : 32'h0);
    chk("mem_we", 32'(mem_we), 32'(ok && we[g]));
    chk("mem_re", 32'(mem_re), 32'(ok && !we[g]));
    chk("mem_addr", mem_addr, ok ? a : 32'h0);
    chk("mem_wdata", mem_wdata, ok ? d : 32'h0);
    obs_ack = ack; obs_err = err; obs_rvalid = rvalid; obs_rdata = rdata; obs_re = mem_re;
    @(posedge clk);
    if (rst) begin
      m_ptr = 0;
      m_pend = 1'b0;
    end else begin
      m_pend = ok && !we[g];
      if (m_pend) begin
        m_pid = g;
        m_pdata = ref_mem[a[3:0]];
      end
      if (ok && we[g]) ref_mem[a[3:0]] = d;
      if (g >= 0) m_ptr = (g + 1) % N;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;

    // Reset, with requests asserted to show the memory stays quiet.
    req = 2'b11;
    tick();
    tick();
    chk("rst_ack", 32'(obs_ack), 32'h0);
    chk("rst_rvalid", 32'(obs_rvalid), 32'h0);
    rst = 1'b0;
    req = '0;

    // Fill memory through the arbiter so bench memory and model agree.
    for (int i = 0; i < 16; i++) begin
      init_data[i] = (i == 3) ? 32'hDEADBEEF : $urandom;
      req = '0;
      set_req(0, 1'b1, 32'(i), init_data[i]);
      tick();
    end
    req = '0;
    tick();

    // Single read.
    set_req(0, 1'b0, 32'd3, 32'h0);
    tick();
    chk("single_ack", 32'(obs_ack), 32'h1);
    req = '0;
    tick();
    chk("single_rvalid", 32'(obs_rvalid), 32'h1);
    chk("single_rdata", obs_rdata, 32'hDEADBEEF);

    // Write then read from requester 1.
    set_req(1, 1'b1, 32'd5, 32'h12345678);
    tick();
    chk("wr_ack", 32'(obs_ack), 32'h2);
    set_req(1, 1'b0, 32'd5, 32'h0);
    tick();
    chk("rd_ack", 32'(obs_ack), 32'h2);
    req = '0;
    tick();
    chk("wr_rd_rvalid", 32'(obs_rvalid), 32'h2);
    chk("wr_rd_rdata", obs_rdata, 32'h12345678);

    // Contention straight after reset alternates 0,1,0,1,...
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 1'b0, 32'd1, 32'h0);
    set_req(1, 1'b0, 32'd2, 32'h0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("contend_ack", 32'(obs_ack), (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    req = '0;
    tick();

    // Out-of-range read.
    set_req(0, 1'b0, 32'd16, 32'h0);
    tick();
    chk("oor_ack", 32'(obs_ack), 32'h1);
    chk("oor_err", 32'(obs_err), 32'h1);
    chk("oor_mem_re", 32'(obs_re), 32'h0);
    req = '0;
    tick();
    chk("oor_no_rvalid", 32'(obs_rvalid), 32'h0);

    // Reset in the cycle after a read ack.
    set_req(0, 1'b0, 32'd3, 32'h0);
    tick();
    chk("mid_ack", 32'(obs_ack), 32'h1);
    req = '0;
    rst = 1'b1;
    tick();
    chk("mid_rst_rvalid", 32'(obs_rvalid), 32'h0);
    rst = 1'b0;
    tick();
    chk("mid_after_rvalid", 32'(obs_rvalid), 32'h0);
    set_req(0, 1'b0, 32'd4, 32'h0);
    set_req(1, 1'b0, 32'd6, 32'h0);
    tick();
    chk("mid_first_grant", 32'(obs_ack), 32'h1);
    req = '0;
    tick();

    // Pipelined reads from requester 0.
    set_req(0, 1'b0, 32'd1, 32'h0);
    tick();
    set_req(0, 1'b0, 32'd2, 32'h0);
    tick();
    chk("pipe_rvalid0", 32'(obs_rvalid), 32'h1);
    chk("pipe_rdata0", obs_rdata, init_data[1]);
    req = '0;
    tick();
    chk("pipe_rvalid1", 32'(obs_rvalid), 32'h1);
    chk("pipe_rdata1", obs_rdata, init_data[2]);

    // Random traffic, including out-of-range addresses and occasional reset.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < N; i++) begin
        req[i] = $urandom_range(0, 3) != 0;
        we[i]  = $urandom_range(0, 1) == 1;
        addr[32*i +: 32]  = 32'($urandom_range(0, 19));
        wdata[32*i +: 32] = $urandom;
      end
      tick();
    end
    rst = 1'b0;
    req = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between NUM_REQ processor cores in the MP-NoC.
- Grants one access per cycle using round-robin arbitration and drives the data memory's write-enable, read-enable, address and write-data inputs.
- Captures the memory's registered read data one cycle after issue and routes it back to the requester that issued the read.
- Rejects out-of-range addresses without touching memory.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DEPTH, 16, number of 32-bit words in the data memory
AW, 32, address/data width (fixed 32; present for package use)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester access request, level, held until ack
we  in  NUM_REQ  1=write, 0=read, per requester
addr  in  NUM_REQ*32  word address, requester i at [32i+31:32i]
wdata  in  NUM_REQ*32  write data, same packing
ack  out  NUM_REQ  one-hot pulse: request accepted this cycle
rvalid  out  NUM_REQ  one-hot pulse: rdata valid for requester i
rdata  out  32  read data (shared bus, qualified by rvalid)
err  out  NUM_REQ  one-hot pulse with ack: address >= DEPTH, access dropped
mem_we  out  1  to data memory write enable
mem_re  out  1  to data memory read enable
mem_addr  out  32  to data memory address
mem_wdata  out  32  to data memory write data
mem_rdata  in  32  from data memory registered read port

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): rr_ptr<=0, resp_pending<=0, resp_id<=0; ack, rvalid and err are 0; rdata=0. mem_we, mem_re, mem_addr and mem_wdata are 0 while rst is high.
- Arbitration (combinational, each cycle): scan the req bits starting at rr_ptr, wrapping modulo NUM_REQ. The first set bit is the winner g. With no req set, there is no grant and all mem_* outputs are 0.
- Grant cycle for winner g: ack[g]=1.
  - If addr_g < DEPTH: mem_addr=addr_g, mem_we=we_g, mem_re=~we_g, mem_wdata=wdata_g.
  - Else: err[g]=1 and all mem_* outputs stay 0.
- rr_ptr update: on any grant, rr_ptr <= (g+1) mod NUM_REQ. Otherwise it is unchanged.
- Read response:
  - On a valid read grant: resp_pending<=1, resp_id<=g.
  - Next cycle: rvalid[resp_id]=1 and rdata=mem_rdata (pass-through of the memory's registered output).
  - When resp_pending=0: rvalid=0 and rdata=0.
- Latency:
  - Writes complete at the grant edge.
  - Read data is returned exactly 1 cycle after ack.
  - Back-to-back grants are allowed every cycle. A read response and a new grant may coincide, including for the same requester.
- Requester rule: deassert req, or present a new access, in the cycle after ack. A req held high after ack is treated as a new request.
- Out-of-range access: ack and err pulse together. No rvalid is produced for an out-of-range read.
- Reset mid-read: a pending response is discarded. No rvalid follows reset.
- A single requester active continuously gets a grant every cycle. With all requesters active, each gets exactly 1 grant per NUM_REQ cycles.

Decomposition:
- Package dmem_pkg holds: DEPTH, the data width constant 32, NUM_REQ default, and localparam ID_W=$clog2(NUM_REQ).
- One sub-module: rr_arbiter. It takes req and rr_ptr and returns one-hot grant plus the encoded grant index. It is purely combinational; the pointer register stays in dmem_arbiter.

Test Plan:
- Single read: memory word 3=0xDEADBEEF; req[0] read addr 3 -> ack[0] that cycle; rvalid[0]=1 with rdata=0xDEADBEEF next cycle.
- Write then read: req[1] write addr 5 data 0x12345678; next cycle req[1] read addr 5 -> rvalid[1] with rdata=0x12345678 one cycle after the second ack.
- Contention with NUM_REQ=2, both req held for 6 cycles after reset -> grants alternate 0,1,0,1,0,1.
- Out of range: req[0] read addr 16 -> ack[0]=err[0]=1, mem_re=0, and no rvalid in the following cycle.
- Reset mid-read: rst asserted in the cycle after a read ack -> rvalid stays 0 and rr_ptr returns to 0. The next contended grant goes to requester 0.
- Pipelined reads: req[0] reads addr 1 then addr 2 on consecutive cycles -> rvalid[0] on 2 consecutive cycles with the data of words 1 and 2, in order.
